tick_timer_ctrl: RTL and testbench
==================================

// Module: tick_timer_ctrl
//
// PURPOSE
//   Sequencer that drives the enable of a shared counter datapath.
//   Generates one-cycle 'tick' strobes every (prescale+1) clocks for 'period' ticks, then pulses 'done'.
//   Sits between the control logic (buttons/CPU regs) and counter/display blocks that consume 'tick' as their en.
//
// PARAMETERS
//   W   16  width of period / remaining-tick counter
//   PW   8  width of prescaler
//
// PORTS
//   clk          in   1   clock
//   rst_n        in   1   asynchronous reset, active-low
//   start        in   1   level-sampled request; accepted only in IDLE
//   stop         in   1   abort; returns to IDLE without done
//   period       in   W   number of ticks to issue; latched on accepted start
//   prescale     in   PW  clocks between ticks minus 1; latched on accepted start
//   auto_reload  in   1   periodic mode select (present only with TICK_TIMER_AUTO_RELOAD_EN)
//   tick         out  1   enable strobe for downstream counter
//   done         out  1   one-cycle completion pulse
//   busy         out  1   high whenever state != IDLE
//   remaining    out  W   ticks still to issue in current run
//
// BEHAVIOUR
//   - Reset (async, rst_n=0): state=IDLE, tick=0, done=0, busy=0, remaining=0, prescaler=0, latched regs=0.
//   - States: IDLE, RUN, DONE.
//   - IDLE: start=1 & stop=0 at edge -> latch period/prescale, remaining<=period, pre<=0.
//     If period!=0 go RUN, else go DONE (no ticks issued).
//   - RUN:
//     - pre increments each clock.
//     - When pre==prescale_l: tick=1 that cycle (tick = RUN & pre==prescale_l, decoded from regs),
//       pre<=0, remaining<=remaining-1.
//     - Edge on which remaining goes 1->0 -> DONE.
//   - DONE: done=1 for exactly that cycle, then IDLE next edge.
//   - busy = (state != IDLE); asserted from the cycle after start is accepted.
//   - Timing: prescale=P, period=N, start accepted at edge 0
//     -> ticks in cycles (P+1), 2(P+1) .. N(P+1); done in cycle N(P+1)+1; busy=0 from cycle N(P+1)+2.
//   - stop=1 in RUN or DONE -> IDLE next edge: remaining<=0, pre<=0, no done pulse, no tick that cycle.
//   - stop and start together: stop wins, start not accepted.
//   - start while busy: ignored; period/prescale changes while busy have no effect.
//   - prescale=0: tick every cycle in RUN.
//   - period = 2^W-1 and prescale = 2^PW-1 must run to completion without overflow; remaining never wraps below 0.
//   - rst_n assertion mid-run: immediate return to reset values; tick/done drop asynchronously.
//
// CONFIGURATION
//   TICK_TIMER_AUTO_RELOAD_EN defined:
//     - Port auto_reload exists.
//     - If auto_reload=1 on the edge where remaining goes 1->0: remaining<=period_l, pre<=0, stay RUN,
//       done pulses for one cycle concurrently with continued running.
//     - Tick spacing is unchanged across the reload; auto_reload is sampled at each terminal edge.
//   TICK_TIMER_AUTO_RELOAD_EN undefined:
//     - Port absent; one-shot behaviour only, as above.
//
// TESTING
//   1. Reset mid-run (P=3, N=5, rst_n low at cycle 7) -> all outputs 0 immediately; after release start works normally.
//   2. P=0, N=3, start at edge 0 -> tick high cycles 1,2,3; done cycle 4; busy 0 from cycle 5; remaining 3,2,1,0.
//   3. P=2, N=2 -> ticks at cycles 3 and 6 only; done cycle 7.
//   4. N=0 -> no tick; done one cycle after accept; busy one cycle.
//   5. P=1, N=4; stop at cycle 5 -> exactly 2 ticks; IDLE next edge; no done; start+stop together not accepted.
//   6. (AUTO_RELOAD_EN) P=0, N=2, auto_reload=1 -> ticks every cycle, done pulse every 2nd tick;
//      drop auto_reload -> stop after current run.

Source files
------------

// File: rtl/tick_timer_ctrl.sv
// Tick sequencer: issues 'period' one-cycle tick strobes spaced (prescale+1) clocks apart, then pulses done.
// Optional periodic mode (auto_reload port) is enabled by defining TICK_TIMER_AUTO_RELOAD_EN.
module tick_timer_ctrl #(
    parameter int W  = 16,
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stop,
    input  logic [W-1:0]  period,
    input  logic [PW-1:0] prescale,
`ifdef TICK_TIMER_AUTO_RELOAD_EN
    input  logic          auto_reload,
`endif
    output logic          tick,
    output logic          done,
    output logic          busy,
    output logic [W-1:0]  remaining
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t        state_reg;
    logic [W-1:0]  period_l_reg;
    logic [PW-1:0] prescale_l_reg;
    logic [PW-1:0] pre_reg;
    logic [W-1:0]  remaining_reg;
    logic          done_reg;
    logic          tick_hit;
    logic          reload;

`ifdef TICK_TIMER_AUTO_RELOAD_EN
    assign reload = auto_reload;
`else
    assign reload = 1'b0;
`endif

    // Prescaler terminal count; pre_reg is cleared here so it never wraps.
    assign tick_hit  = (state_reg == S_RUN) && (pre_reg == prescale_l_reg);
    assign tick      = tick_hit && !stop;
    assign done      = done_reg;
    assign busy      = (state_reg != S_IDLE);
    assign remaining = remaining_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            period_l_reg   <= '0;
            prescale_l_reg <= '0;
            pre_reg        <= '0;
            remaining_reg  <= '0;
            done_reg       <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start && !stop) begin
                        period_l_reg   <= period;
                        prescale_l_reg <= prescale;
                        remaining_reg  <= period;
                        pre_reg        <= '0;
                        if (period != '0) begin
                            state_reg <= S_RUN;
                        end else begin
                            state_reg <= S_DONE;
                            done_reg  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        state_reg     <= S_IDLE;
                        remaining_reg <= '0;
                        pre_reg       <= '0;
                    end else if (tick_hit) begin
                        pre_reg <= '0;
                        if (remaining_reg == W'(1)) begin
                            done_reg <= 1'b1;
                            if (reload) begin
                                remaining_reg <= period_l_reg;
                            end else begin
                                remaining_reg <= '0;
                                state_reg     <= S_DONE;
                            end
                        end else begin
                            remaining_reg <= remaining_reg - W'(1);
                        end
                    end else begin
                        pre_reg <= pre_reg + PW'(1);
                    end
                end
                S_DONE: begin
                    state_reg     <= S_IDLE;
                    remaining_reg <= '0;
                    pre_reg       <= '0;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tick_timer_ctrl.sv
// Directed bench for tick_timer_ctrl: per-cycle expectations derived from the tick/done timing formula
// are queued when a run is launched and popped as each cycle's outputs are sampled on the falling edge.
module tb_tick_timer_ctrl;

    localparam int W  = 16;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          stop;
    logic [W-1:0]  period;
    logic [PW-1:0] prescale;
    logic          auto_reload;
    logic          tick;
    logic          done;
    logic          busy;
    logic [W-1:0]  remaining;

    int vectors    = 0;
    int miscompares = 0;
    logic [W+2:0] sb[$];

    tick_timer_ctrl #(.W(W), .PW(PW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .period     (period),
        .prescale   (prescale),
`ifdef TICK_TIMER_AUTO_RELOAD_EN
        .auto_reload(auto_reload),
`endif
        .tick       (tick),
        .done       (done),
        .busy       (busy),
        .remaining  (remaining)
    );

    always #5 clk = ~clk;

    task automatic push(input bit t, input bit d, input bit b, input int r);
        sb.push_back({t, d, b, W'(r)});
    endtask

    task automatic check(input string tag);
        logic [W+2:0] obs;
        logic [W+2:0] exp_v;
        obs = {tick, done, busy, remaining};
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL %s scoreboard empty obs=%h", tag, obs);
        end else begin
            exp_v = sb.pop_front();
            $display("vec %0d %s tick/done/busy/rem obs=%h exp=%h", vectors, tag, obs, exp_v);
            assert (obs === exp_v) else begin
                miscompares++;
                $display("FAIL %s tick/done/busy/rem obs=%h exp=%h", tag, obs, exp_v);
                $error("%s miscompare", tag);
            end
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        @(negedge clk);
        check(tag);
    endtask

    // Launch a one-shot run at the next edge and check cycles 1..min(limit, N(P+1)+2).
    task automatic oneshot(input string tag, input int p, input int n, input int limit);
        int m;
        int last;
        m = n * (p + 1);
        last = (limit < m + 2) ? limit : m + 2;
        period = W'(n);
        prescale = PW'(p);
        start = 1'b1;
        for (int c = 1; c <= last; c++)
            push((c % (p + 1) == 0) && (c <= m), c == m + 1, c <= m + 1,
                 (c > m) ? 0 : n - (c - 1) / (p + 1));
        for (int c = 1; c <= last; c++) begin
            step(tag);
            start = 1'b0;
            if (c == 1) begin
                period = 16'h0007;
                prescale = 8'h00;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        period = '0;
        prescale = '0;
        auto_reload = 1'b0;

        push(0, 0, 0, 0);
        step("reset_state");
        @(negedge clk);
        rst_n = 1'b1;
        push(0, 0, 0, 0);
        step("idle_after_reset");

        // Reset mid-run: P=3, N=5, reset asserted in cycle 7.
        oneshot("reset_midrun", 3, 5, 7);
        rst_n = 1'b0;
        #1;
        push(0, 0, 0, 0);
        check("reset_async");
        push(0, 0, 0, 0);
        step("reset_held");
        @(negedge clk);
        rst_n = 1'b1;

        oneshot("p0_n3", 0, 3, 1000);
        oneshot("p2_n2", 2, 2, 1000);
        oneshot("n0", 0, 0, 1000);
        oneshot("p255_n2", 255, 2, 1000);

        // Stop in cycle 5 of P=1, N=4 run: two ticks only, no done.
        oneshot("stop_run", 1, 4, 5);
        stop = 1'b1;
        push(0, 0, 0, 0);
        step("stop_idle");
        start = 1'b1;
        push(0, 0, 0, 0);
        push(0, 0, 0, 0);
        step("start_stop_together");
        step("start_stop_together2");
        start = 1'b0;
        stop = 1'b0;

        // Stop suppresses a tick in the same cycle.
        oneshot("stop_tick", 0, 3, 1);
        stop = 1'b1;
        #1;
        push(0, 0, 1, 3);
        check("stop_masks_tick");
        push(0, 0, 0, 0);
        step("stop_masks_idle");
        stop = 1'b0;

`ifdef TICK_TIMER_AUTO_RELOAD_EN
        auto_reload = 1'b1;
        period = 16'd2;
        prescale = 8'd0;
        start = 1'b1;
        for (int c = 1; c <= 6; c++)
            push(1, (c % 2 == 1) && (c >= 3), 1, (c % 2 == 1) ? 2 : 1);
        push(0, 1, 1, 0);
        push(0, 0, 0, 0);
        for (int c = 1; c <= 8; c++) begin
            step("auto_reload");
            start = 1'b0;
            if (c == 5) auto_reload = 1'b0;
        end
`endif

        push(0, 0, 0, 0);
        step("final_idle");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
